alu_op_sequencer: RTL and testbench

Multicycle control sequencer that drives the 32-bit ALU: it fetches an instruction, decodes it, and issues the ALU `func` code and operand selects. It evaluates the ALU `Z_flag` for branches and sequences the memory and register-file strobes for each instruction class. It is the initiator side of the ALU `func`/`Z_flag` interface and sits between the instruction register and the datapath muxes.

---
 rtl/alu_seq_pkg.sv | 84 ++++++++
 rtl/alu_func_decode.sv | 83 ++++++++
 rtl/alu_op_sequencer.sv | 131 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and encodings for the multicycle ALU control sequencer:
// FSM states, instruction fields, ALU function codes and datapath mux selects.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BRANCH
  } state_e;

  typedef enum logic [2:0] {
    CLS_RTYPE, CLS_ITYPE, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP
  } instr_class_e;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE    = 6'd0;
  localparam logic [5:0] OP_J        = 6'd2;
  localparam logic [5:0] OP_BEQ      = 6'd4;
  localparam logic [5:0] OP_BNE      = 6'd5;
  localparam logic [5:0] OP_BLEZ     = 6'd6;
  localparam logic [5:0] OP_BGTZ     = 6'd7;
  localparam logic [5:0] OP_ADDI     = 6'd8;
  localparam logic [5:0] OP_ADDIU    = 6'd9;
  localparam logic [5:0] OP_SLTI     = 6'd10;
  localparam logic [5:0] OP_SLTIU    = 6'd11;
  localparam logic [5:0] OP_ANDI     = 6'd12;
  localparam logic [5:0] OP_ORI      = 6'd13;
  localparam logic [5:0] OP_XORI     = 6'd14;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_LW       = 6'd35;
  localparam logic [5:0] OP_SW       = 6'd43;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] F_SLL  = 6'd0;
  localparam logic [5:0] F_SRL  = 6'd2;
  localparam logic [5:0] F_SRA  = 6'd3;
  localparam logic [5:0] F_SLLV = 6'd4;
  localparam logic [5:0] F_SRLV = 6'd6;
  localparam logic [5:0] F_SRAV = 6'd7;
  localparam logic [5:0] F_ADD  = 6'd32;
  localparam logic [5:0] F_ADDU = 6'd33;
  localparam logic [5:0] F_SUB  = 6'd34;
  localparam logic [5:0] F_SUBU = 6'd35;
  localparam logic [5:0] F_AND  = 6'd36;
  localparam logic [5:0] F_OR   = 6'd37;
  localparam logic [5:0] F_XOR  = 6'd38;
  localparam logic [5:0] F_NOR  = 6'd39;
  localparam logic [5:0] F_SLT  = 6'd42;
  localparam logic [5:0] F_SLTU = 6'd43;
  localparam logic [5:0] F_CLZ  = 6'h20;
  localparam logic [5:0] F_CLO  = 6'h21;

  // ALU function codes
  localparam logic [5:0] ALU_SLL  = 6'd4;
  localparam logic [5:0] ALU_SRL  = 6'd6;
  localparam logic [5:0] ALU_CLZ  = 6'd7;
  localparam logic [5:0] ALU_ADD  = 6'd32;
  localparam logic [5:0] ALU_ADDU = 6'd33;
  localparam logic [5:0] ALU_SUB  = 6'd34;
  localparam logic [5:0] ALU_AND  = 6'd36;
  localparam logic [5:0] ALU_OR   = 6'd37;
  localparam logic [5:0] ALU_XOR  = 6'd38;
  localparam logic [5:0] ALU_SLT  = 6'd42;
  localparam logic [5:0] ALU_SLTU = 6'd43;
  localparam logic [5:0] ALU_SRA  = 6'd48;
  localparam logic [5:0] ALU_GTZ  = 6'd50;
  localparam logic [5:0] ALU_EQZ  = 6'd52;
  localparam logic [5:0] ALU_LEZ  = 6'd54;
  localparam logic [5:0] ALU_CLO  = 6'd56;

  // Operand and next-PC selects
  localparam logic [1:0] A_PC       = 2'd0;
  localparam logic [1:0] A_RS       = 2'd1;
  localparam logic [1:0] A_RT       = 2'd2;
  localparam logic [2:0] B_RT       = 3'd0;
  localparam logic [2:0] B_FOUR     = 3'd1;
  localparam logic [2:0] B_SIMM     = 3'd2;
  localparam logic [2:0] B_SHAMT    = 3'd3;
  localparam logic [2:0] B_RS       = 3'd4;
  localparam logic [2:0] B_ZIMM     = 3'd5;
  localparam logic [2:0] B_SIMM_SH2 = 3'd6;
  localparam logic [1:0] PC_ALU     = 2'd0;
  localparam logic [1:0] PC_TARGET  = 2'd1;
  localparam logic [1:0] PC_JUMP    = 2'd2;

endpackage

// File: rtl/alu_func_decode.sv
// Combinational instruction decode: ALU func, operand selects, class, legality.
// ALU_SEQ_CLZ_CLO_EN enables the SPECIAL2 CLZ/CLO encodings.
module alu_func_decode
  import alu_seq_pkg::*;
(
  input  logic [31:0] instr,
  output logic [5:0]  func,
  output logic [1:0]  a_sel,
  output logic [2:0]  b_sel,
  output logic [2:0]  cls,
  output logic        branch_on_z,
  output logic        legal
);

  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [5:0] funct;
  logic       unused_imm;

  assign opcode     = instr[31:26];
  assign rs         = instr[25:21];
  assign rt         = instr[20:16];
  assign funct      = instr[5:0];
  assign unused_imm = ^instr[15:6];

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    func        = ALU_ADDU;
    a_sel       = A_RS;
    b_sel       = B_RT;
    cls         = CLS_RTYPE;
    branch_on_z = 1'b1;
    legal       = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_SLL:  begin func = ALU_SLL; a_sel = A_RT; b_sel = B_SHAMT; end
          F_SRL:  begin func = ALU_SRL; a_sel = A_RT; b_sel = B_SHAMT; end
          F_SRA:  begin func = ALU_SRA; a_sel = A_RT; b_sel = B_SHAMT; end
          F_SLLV: begin func = ALU_SLL; a_sel = A_RT; b_sel = B_RS;    end
          F_SRLV: begin func = ALU_SRL; a_sel = A_RT; b_sel = B_RS;    end
          F_SRAV: begin func = ALU_SRA; a_sel = A_RT; b_sel = B_RS;    end
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
          F_SLT, F_SLTU: func = funct;
          default: legal = 1'b0;
        endcase
      end
      OP_J: cls = CLS_JUMP;
      OP_BEQ: begin
        cls  = CLS_BRANCH;
        // beq $0,$0 is the unconditional-branch idiom; test zero directly
        func = (rs == 5'd0 && rt == 5'd0) ? ALU_EQZ : ALU_SUB;
      end
      OP_BNE:   begin cls = CLS_BRANCH; func = ALU_SUB; branch_on_z = 1'b0; end
      OP_BLEZ:  begin cls = CLS_BRANCH; func = ALU_LEZ; end
      OP_BGTZ:  begin cls = CLS_BRANCH; func = ALU_GTZ; end
      OP_ADDI:  begin cls = CLS_ITYPE; func = ALU_ADD;  b_sel = B_SIMM; end
      OP_ADDIU: begin cls = CLS_ITYPE; func = ALU_ADDU; b_sel = B_SIMM; end
      OP_SLTI:  begin cls = CLS_ITYPE; func = ALU_SLT;  b_sel = B_SIMM; end
      OP_SLTIU: begin cls = CLS_ITYPE; func = ALU_SLTU; b_sel = B_SIMM; end
      OP_ANDI:  begin cls = CLS_ITYPE; func = ALU_AND;  b_sel = B_ZIMM; end
      OP_ORI:   begin cls = CLS_ITYPE; func = ALU_OR;   b_sel = B_ZIMM; end
      OP_XORI:  begin cls = CLS_ITYPE; func = ALU_XOR;  b_sel = B_ZIMM; end
      OP_LW:    begin cls = CLS_LOAD;  func = ALU_ADDU; b_sel = B_SIMM; end
      OP_SW:    begin cls = CLS_STORE; func = ALU_ADDU; b_sel = B_SIMM; end
`ifdef ALU_SEQ_CLZ_CLO_EN
      OP_SPECIAL2: begin
        case (funct)
          F_CLZ:   func = ALU_CLZ;
          F_CLO:   func = ALU_CLO;
          default: legal = 1'b0;
        endcase
      end
`else
      OP_SPECIAL2: legal = 1'b0;
`endif
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multicycle control FSM driving the ALU func/select interface and the
// memory/register-file strobes; outputs are combinational from state and instr.
module alu_op_sequencer
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        z_flag,
  output logic [5:0]  alu_func,
  output logic [1:0]  alu_a_sel,
  output logic [2:0]  alu_b_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic        target_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  pc_src,
  output logic        illegal
);

  state_e     state_q;
  state_e     state_d;
  logic [5:0] dec_func;
  logic [1:0] dec_a_sel;
  logic [2:0] dec_b_sel;
  logic [2:0] dec_cls;
  logic       dec_branch_on_z;
  logic       dec_legal;

  alu_func_decode u_decode (
    .instr       (instr),
    .func        (dec_func),
    .a_sel       (dec_a_sel),
    .b_sel       (dec_b_sel),
    .cls         (dec_cls),
    .branch_on_z (dec_branch_on_z),
    .legal       (dec_legal)
  );

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    alu_func     = ALU_ADDU;
    alu_a_sel    = A_PC;
    alu_b_sel    = B_RT;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    target_write = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    pc_src       = PC_ALU;
    illegal      = 1'b0;
    // Outputs stay quiet for the whole reset cycle so no write lands mid-reset
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_b_sel = B_FOUR;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_b_sel    = B_SIMM_SH2;
          target_write = 1'b1;
          if (!dec_legal) begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end else if (dec_cls == CLS_JUMP) begin
            pc_write = 1'b1;
            pc_src   = PC_JUMP;
            state_d  = S_FETCH;
          end else if (dec_cls == CLS_BRANCH) begin
            state_d = S_BRANCH;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          alu_func  = dec_func;
          alu_a_sel = dec_a_sel;
          alu_b_sel = dec_b_sel;
          state_d   = (dec_cls == CLS_LOAD || dec_cls == CLS_STORE) ? S_MEM : S_WB;
        end
        S_MEM: begin
          // Keep the address computation on the ALU while memory is busy
          alu_func  = dec_func;
          alu_a_sel = dec_a_sel;
          alu_b_sel = dec_b_sel;
          mem_read  = (dec_cls == CLS_LOAD);
          mem_write = (dec_cls != CLS_LOAD);
          if (mem_ready) state_d = (dec_cls == CLS_LOAD) ? S_WB : S_FETCH;
        end
        S_WB: begin
          reg_write  = 1'b1;
          reg_dst    = (dec_cls == CLS_RTYPE);
          mem_to_reg = (dec_cls == CLS_LOAD);
          state_d    = S_FETCH;
        end
        S_BRANCH: begin
          alu_func  = dec_func;
          alu_a_sel = A_RS;
          alu_b_sel = B_RT;
          if (z_flag == dec_branch_on_z) begin
            pc_write = 1'b1;
            pc_src   = PC_TARGET;
          end
          state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer; expected values are hand-derived.
// Define ALU_SEQ_CLZ_CLO_EN for both bench and RTL to exercise CLZ/CLO.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        mem_ready;
  logic        z_flag;
  logic [5:0]  alu_func;
  logic [1:0]  alu_a_sel;
  logic [2:0]  alu_b_sel;
  logic        ir_write, pc_write, target_write, reg_write;
  logic        reg_dst, mem_to_reg, mem_read, mem_write;
  logic [1:0]  pc_src;
  logic        illegal;
  logic [7:0]  strobes;

  int total = 0;
  int bad   = 0;

  // Strobe bit positions: ir pc tgt rw rdst m2r mrd mwr
  localparam logic [7:0] S_IR = 8'h80, S_PC = 8'h40, S_TGT = 8'h20, S_RW = 8'h10;
  localparam logic [7:0] S_RDST = 8'h08, S_M2R = 8'h04, S_MRD = 8'h02, S_MWR = 8'h01;
  localparam logic [7:0] S_NONE = 8'h00;

  localparam logic [31:0] I_ADD    = {6'd0,  5'd1, 5'd2, 5'd3, 5'd0, 6'd32};
  localparam logic [31:0] I_SLL    = {6'd0,  5'd0, 5'd2, 5'd3, 5'd5, 6'd0};
  localparam logic [31:0] I_SRA    = {6'd0,  5'd0, 5'd2, 5'd3, 5'd7, 6'd3};
  localparam logic [31:0] I_SRLV   = {6'd0,  5'd4, 5'd2, 5'd3, 5'd0, 6'd6};
  localparam logic [31:0] I_BADFN  = {6'd0,  5'd1, 5'd0, 5'd0, 5'd0, 6'd8};
  localparam logic [31:0] I_LW     = {6'd35, 5'd1, 5'd2, 16'h0010};
  localparam logic [31:0] I_SW     = {6'd43, 5'd1, 5'd2, 16'h0020};
  localparam logic [31:0] I_BEQ    = {6'd4,  5'd1, 5'd2, 16'h0003};
  localparam logic [31:0] I_BEQ00  = {6'd4,  5'd0, 5'd0, 16'h0003};
  localparam logic [31:0] I_BNE    = {6'd5,  5'd1, 5'd2, 16'h0003};
  localparam logic [31:0] I_BGTZ   = {6'd7,  5'd1, 5'd0, 16'h0003};
  localparam logic [31:0] I_J      = {6'd2,  26'h0000100};
  localparam logic [31:0] I_ORI    = {6'd13, 5'd1, 5'd2, 16'hF00F};
  localparam logic [31:0] I_ADDI   = {6'd8,  5'd1, 5'd2, 16'hFFFF};
  localparam logic [31:0] I_BADOP  = {6'h3F, 26'h0};
  localparam logic [31:0] I_CLZ    = {6'h1C, 5'd1, 5'd0, 5'd3, 5'd0, 6'h20};

  assign strobes = {ir_write, pc_write, target_write, reg_write,
                    reg_dst, mem_to_reg, mem_read, mem_write};

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .mem_ready    (mem_ready),
    .z_flag       (z_flag),
    .alu_func     (alu_func),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .target_write (target_write),
    .reg_write    (reg_write),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .pc_src       (pc_src),
    .illegal      (illegal)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Called just after a falling edge with inputs set; checks, then advances
  // one full cycle. ops=0 skips func/selects where they carry no meaning.
  task automatic cyc(input string tag, input bit ops, input logic [5:0] f,
                     input logic [1:0] a, input logic [2:0] b, input logic [7:0] s,
                     input logic [1:0] p, input logic il);
    #1;
    if (ops) begin
      check({tag, ".func"}, 8'(alu_func), 8'(f));
      check({tag, ".a"}, 8'(alu_a_sel), 8'(a));
      check({tag, ".b"}, 8'(alu_b_sel), 8'(b));
    end
    check({tag, ".strb"}, strobes, s);
    check({tag, ".pcsrc"}, 8'(pc_src), 8'(p));
    check({tag, ".ill"}, 8'(illegal), 8'(il));
    @(posedge clk);
    @(negedge clk);
  endtask

  // One zero-wait FETCH followed by the DECODE cycle
  task automatic fetch_decode(input string tag, input logic [31:0] ins);
    instr     = ins;
    mem_ready = 1'b1;
    cyc({tag, ".fetch"}, 1, 33, 0, 1, S_IR | S_PC | S_MRD, 0, 0);
    mem_ready = 1'b0;
    cyc({tag, ".dec"}, 1, 33, 0, 6, S_TGT, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; instr = '0; mem_ready = 1'b0; z_flag = 1'b0;
    @(negedge clk);
    cyc("reset", 1, 33, 0, 0, S_NONE, 0, 0);
    rst_n = 1'b1;

    // ADD with memory two cycles late; mem_ready high (ignored) after fetch
    cyc("add.f0", 1, 33, 0, 1, S_MRD, 0, 0);
    cyc("add.f1", 1, 33, 0, 1, S_MRD, 0, 0);
    mem_ready = 1'b1; instr = I_ADD;
    cyc("add.f2", 1, 33, 0, 1, S_IR | S_PC | S_MRD, 0, 0);
    cyc("add.dec", 1, 33, 0, 6, S_TGT, 0, 0);
    cyc("add.exe", 1, 32, 1, 0, S_NONE, 0, 0);
    cyc("add.wb", 0, 0, 0, 0, S_RW | S_RDST, 0, 0);
    mem_ready = 1'b0;
    cyc("add.next", 1, 33, 0, 1, S_MRD, 0, 0);

    // Reset asserted while in EXEC
    fetch_decode("rexe", I_ADD);
    rst_n = 1'b0;
    cyc("rexe.rst", 1, 33, 0, 0, S_NONE, 0, 0);
    rst_n = 1'b1;
    cyc("rexe.fetch", 1, 33, 0, 1, S_MRD, 0, 0);

    // LW with one memory wait
    fetch_decode("lw", I_LW);
    cyc("lw.exe", 1, 33, 1, 2, S_NONE, 0, 0);
    cyc("lw.mem0", 0, 0, 0, 0, S_MRD, 0, 0);
    mem_ready = 1'b1;
    cyc("lw.mem1", 0, 0, 0, 0, S_MRD, 0, 0);
    mem_ready = 1'b0;
    cyc("lw.wb", 0, 0, 0, 0, S_RW | S_M2R, 0, 0);
    cyc("lw.next", 1, 33, 0, 1, S_MRD, 0, 0);

    // SW zero-wait
    fetch_decode("sw", I_SW);
    cyc("sw.exe", 1, 33, 1, 2, S_NONE, 0, 0);
    mem_ready = 1'b1;
    cyc("sw.mem", 0, 0, 0, 0, S_MWR, 0, 0);
    mem_ready = 1'b0;
    cyc("sw.next", 1, 33, 0, 1, S_MRD, 0, 0);

    // Branches
    fetch_decode("beq1", I_BEQ);
    z_flag = 1'b1;
    cyc("beq1.br", 1, 34, 1, 0, S_PC, 1, 0);
    z_flag = 1'b0;
    fetch_decode("beq0", I_BEQ);
    cyc("beq0.br", 1, 34, 1, 0, S_NONE, 0, 0);
    fetch_decode("beqz", I_BEQ00);
    z_flag = 1'b1;
    cyc("beqz.br", 1, 52, 1, 0, S_PC, 1, 0);
    z_flag = 1'b0;
    fetch_decode("bne", I_BNE);
    cyc("bne.br", 1, 34, 1, 0, S_PC, 1, 0);
    z_flag = 1'b1;
    fetch_decode("bgtz", I_BGTZ);
    cyc("bgtz.br", 1, 50, 1, 0, S_PC, 1, 0);
    z_flag = 1'b0;
    cyc("br.next", 1, 33, 0, 1, S_MRD, 0, 0);

    // Jump: two cycles
    instr = I_J; mem_ready = 1'b1;
    cyc("j.fetch", 1, 33, 0, 1, S_IR | S_PC | S_MRD, 0, 0);
    mem_ready = 1'b0;
    cyc("j.dec", 1, 33, 0, 6, S_TGT | S_PC, 2, 0);
    cyc("j.next", 1, 33, 0, 1, S_MRD, 0, 0);

    // Shifts and immediates
    fetch_decode("sll", I_SLL);
    cyc("sll.exe", 1, 4, 2, 3, S_NONE, 0, 0);
    cyc("sll.wb", 0, 0, 0, 0, S_RW | S_RDST, 0, 0);
    fetch_decode("sra", I_SRA);
    cyc("sra.exe", 1, 48, 2, 3, S_NONE, 0, 0);
    cyc("sra.wb", 0, 0, 0, 0, S_RW | S_RDST, 0, 0);
    fetch_decode("srlv", I_SRLV);
    cyc("srlv.exe", 1, 6, 2, 4, S_NONE, 0, 0);
    cyc("srlv.wb", 0, 0, 0, 0, S_RW | S_RDST, 0, 0);
    fetch_decode("ori", I_ORI);
    cyc("ori.exe", 1, 37, 1, 5, S_NONE, 0, 0);
    cyc("ori.wb", 0, 0, 0, 0, S_RW, 0, 0);
    fetch_decode("addi", I_ADDI);
    cyc("addi.exe", 1, 32, 1, 2, S_NONE, 0, 0);
    cyc("addi.wb", 0, 0, 0, 0, S_RW, 0, 0);

    // Illegal encodings pulse illegal for one cycle, then FETCH
    instr = I_BADFN; mem_ready = 1'b1;
    cyc("badfn.fetch", 1, 33, 0, 1, S_IR | S_PC | S_MRD, 0, 0);
    mem_ready = 1'b0;
    cyc("badfn.dec", 1, 33, 0, 6, S_TGT, 0, 1);
    cyc("badfn.next", 1, 33, 0, 1, S_MRD, 0, 0);
    instr = I_BADOP; mem_ready = 1'b1;
    cyc("badop.fetch", 1, 33, 0, 1, S_IR | S_PC | S_MRD, 0, 0);
    mem_ready = 1'b0;
    cyc("badop.dec", 1, 33, 0, 6, S_TGT, 0, 1);
    cyc("badop.next", 1, 33, 0, 1, S_MRD, 0, 0);

    // SPECIAL2 CLZ
    instr = I_CLZ; mem_ready = 1'b1;
    cyc("clz.fetch", 1, 33, 0, 1, S_IR | S_PC | S_MRD, 0, 0);
    mem_ready = 1'b0;
`ifdef ALU_SEQ_CLZ_CLO_EN
    cyc("clz.dec", 1, 33, 0, 6, S_TGT, 0, 0);
    #1;
    check("clz.exe.func", 8'(alu_func), 8'd7);
    check("clz.exe.a", 8'(alu_a_sel), 8'd1);
    check("clz.exe.strb", strobes, S_NONE);
    @(posedge clk);
    @(negedge clk);
    cyc("clz.wb", 0, 0, 0, 0, S_RW | S_RDST, 0, 0);
`else
    cyc("clz.dec", 1, 33, 0, 6, S_TGT, 0, 1);
`endif
    cyc("clz.next", 1, 33, 0, 1, S_MRD, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
